// File: rtl/ws2812_frame_scheduler_pkg.sv
// Shared types and constants for the WS2812 column frame scheduler.
package ws2812_frame_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    START = 3'd2,
    BUSY  = 3'd3,
    GAP   = 3'd4
  } sched_state_e;

  localparam int BITS_PER_LED          = 24;
  localparam int DEFAULT_LED_COUNT     = 8;
  localparam int DEFAULT_NUM_COLUMNS   = 64;
  localparam int DEFAULT_GAP_CYCLES    = 2500;
  localparam int DEFAULT_START_TIMEOUT = 16;

  // A window of N clocks is timed by loading N-1 and waiting for zero.
  function automatic int timer_reload(input int cycles);
    return (cycles > 1) ? cycles - 1 : 0;
  endfunction

endpackage

// File: rtl/ws2812_gap_timer.sv
// Loadable down-counter shared by the start timeout and the inter-frame gap.
module ws2812_gap_timer #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // Reload on request, otherwise count down and rest at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/ws2812_frame_scheduler.sv
// Fetches one column per frame tick and hands it to the WS2812 driver,
// enforcing a start handshake, a start timeout and a latch gap between frames.
module ws2812_frame_scheduler
  import ws2812_frame_scheduler_pkg::*;
#(
  parameter int LED_COUNT     = DEFAULT_LED_COUNT,
  parameter int NUM_COLUMNS   = DEFAULT_NUM_COLUMNS,
  parameter int GAP_CYCLES    = DEFAULT_GAP_CYCLES,
  parameter int START_TIMEOUT = DEFAULT_START_TIMEOUT,
  localparam int COL_W   = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1,
  localparam int FRAME_W = LED_COUNT * BITS_PER_LED
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               frame_tick,
  input  logic               index,
  output logic [COL_W-1:0]   col_addr,
  input  logic [FRAME_W-1:0] mem_data,
  output logic               drv_start,
  output logic [FRAME_W-1:0] drv_data,
  input  logic               drv_busy,
  output logic               frame_done,
  output logic               overrun,
  output logic               timeout_err,
  input  logic               clear_status
);

  localparam int TIMER_MAX = (GAP_CYCLES > START_TIMEOUT) ? GAP_CYCLES : START_TIMEOUT;
  localparam int TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;
  localparam logic [TIMER_W-1:0] START_RELOAD = TIMER_W'(timer_reload(START_TIMEOUT));
  localparam logic [TIMER_W-1:0] GAP_RELOAD   = TIMER_W'(timer_reload(GAP_CYCLES));
  localparam logic [COL_W-1:0]   LAST_COL     = COL_W'(NUM_COLUMNS - 1);

  sched_state_e       state;
  logic               pending;
  logic               index_pending;
  logic               launch;
  logic               advance;
  logic               timeout_hit;
  logic               overrun_event;
  logic               timer_load;
  logic               timer_done;
  logic [TIMER_W-1:0] timer_value;

  ws2812_gap_timer #(
    .WIDTH(TIMER_W)
  ) u_gap_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (timer_load),
    .load_value(timer_value),
    .done      (timer_done)
  );

  // Decode this cycle's transitions and arm the timer for the window being entered.
  always_comb begin
    launch        = (state == IDLE) && enable && pending;
    timeout_hit   = (state == START) && !drv_busy && timer_done;
    advance       = (state == BUSY) && !drv_busy;
    overrun_event = enable && frame_tick && pending && !launch;
    timer_load    = 1'b0;
    timer_value   = GAP_RELOAD;
    if (state == FETCH) begin
      timer_load  = 1'b1;
      timer_value = START_RELOAD;
    end else if (timeout_hit || advance) begin
      timer_load  = 1'b1;
    end
  end

  // Frame sequencing, tick/index bookkeeping and sticky status, all registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      col_addr      <= '0;
      drv_start     <= 1'b0;
      drv_data      <= '0;
      frame_done    <= 1'b0;
      overrun       <= 1'b0;
      timeout_err   <= 1'b0;
      pending       <= 1'b0;
      index_pending <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (!enable) begin
        pending <= 1'b0;
      end else if (launch) begin
        pending <= frame_tick;
      end else if (frame_tick) begin
        pending <= 1'b1;
      end

      if (overrun_event) begin
        overrun <= 1'b1;
      end else if (clear_status) begin
        overrun <= 1'b0;
      end

      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end else if (clear_status) begin
        timeout_err <= 1'b0;
      end

      if (advance) begin
        index_pending <= 1'b0;
        if (index || index_pending || (col_addr == LAST_COL)) begin
          col_addr <= '0;
        end else begin
          col_addr <= col_addr + COL_W'(1);
        end
      end else if ((state == IDLE && !launch) || (state == GAP && timer_done)) begin
        if (index || index_pending) begin
          col_addr      <= '0;
          index_pending <= 1'b0;
        end
      end else if (index) begin
        index_pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (launch) begin
            state <= FETCH;
          end
        end
        FETCH: begin
          drv_data  <= mem_data;
          drv_start <= 1'b1;
          state     <= START;
        end
        START: begin
          if (drv_busy) begin
            drv_start <= 1'b0;
            state     <= BUSY;
          end else if (timer_done) begin
            drv_start <= 1'b0;
            state     <= GAP;
          end
        end
        BUSY: begin
          if (!drv_busy) begin
            frame_done <= 1'b1;
            state      <= GAP;
          end
        end
        GAP: begin
          if (timer_done) begin
            state <= IDLE;
          end
        end
        default: begin
          drv_start <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_frame_scheduler.sv
// Testbench for ws2812_frame_scheduler: a column memory, a handshaking driver
// model and a frame-level reference model checked every clock.
module tb_ws2812_frame_scheduler;

  localparam int LEDS_C  = 2;
  localparam int COLS_C  = 4;
  localparam int GAP_C   = 20;
  localparam int TOUT_C  = 16;
  localparam int FW      = LEDS_C * 24;
  localparam int CW      = 2;

  logic          clk;
  logic          reset;
  logic          enable;
  logic          frame_tick;
  logic          index;
  logic          clear_status;
  logic          drv_busy;
  logic [FW-1:0] mem_data;
  logic [CW-1:0] col_addr;
  logic          drv_start;
  logic [FW-1:0] drv_data;
  logic          frame_done;
  logic          overrun;
  logic          timeout_err;

  int checks = 0;
  int errors = 0;

  int            cycle = 0;
  int            model_col = 0;
  bit            idx_flag = 0;
  bit            prev_start = 0;
  int            start_len = 0;
  int            last_start_len = 0;
  int            exp_start_len = 3;
  int            end_cycle = 0;
  bit            have_end = 0;
  logic [FW-1:0] held_data = '0;
  int            frames_seen = 0;
  int            rises = 0;
  int            drv_mode = 0;
  int            busy_len = 4;

  ws2812_frame_scheduler #(
    .LED_COUNT    (LEDS_C),
    .NUM_COLUMNS  (COLS_C),
    .GAP_CYCLES   (GAP_C),
    .START_TIMEOUT(TOUT_C)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .frame_tick  (frame_tick),
    .index       (index),
    .col_addr    (col_addr),
    .mem_data    (mem_data),
    .drv_start   (drv_start),
    .drv_data    (drv_data),
    .drv_busy    (drv_busy),
    .frame_done  (frame_done),
    .overrun     (overrun),
    .timeout_err (timeout_err),
    .clear_status(clear_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Column content is a recognisable function of the column number.
  function automatic logic [FW-1:0] pattern(input int c);
    logic [7:0] b;
    b = 8'(c);
    return {b, 8'hC3, 8'h5A, b + 8'h10, 8'h96, 8'h11};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkAtLeast(input string name, input int actual, input int minimum);
    checks++;
    if (actual < minimum) begin
      errors++;
      $display("[TB] FAIL %s: got %0d required at least %0d", name, actual, minimum);
    end
  endtask

  task automatic applyStimulus(input bit tick, input bit idx, input bit clr);
    @(negedge clk);
    frame_tick   = tick;
    index        = idx;
    clear_status = clr;
    if (idx) idx_flag = 1'b1;
    @(negedge clk);
    frame_tick   = 1'b0;
    index        = 1'b0;
    clear_status = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitFrames(input int target, input int budget);
    int n;
    n = 0;
    while (frames_seen < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checkOutput("frames_seen", 64'(frames_seen), 64'(target));
  endtask

  // Synchronous column memory: data follows the address one clock later.
  initial begin : column_memory
    mem_data = '0;
    forever begin
      @(negedge clk);
      mem_data = pattern(int'(col_addr));
    end
  end

  // Driver model: goes busy during the third clock of drv_start, stays busy busy_len clocks.
  initial begin : driver_model
    int cnt;
    int bcnt;
    cnt = 0;
    bcnt = 0;
    drv_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        drv_busy = 1'b0;
        cnt = 0;
        bcnt = 0;
      end else if (drv_busy) begin
        bcnt++;
        if (bcnt >= busy_len) begin
          drv_busy = 1'b0;
          bcnt = 0;
        end
      end else if (drv_mode == 0 && drv_start) begin
        cnt++;
        if (cnt >= 3) begin
          drv_busy = 1'b1;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Frame-level reference: column sequence, frame contents, start length and spacing.
  always @(negedge clk) begin
    cycle++;
    if (!reset) begin
      model_col  = 0;
      prev_start = 1'b0;
      start_len  = 0;
      have_end   = 1'b0;
    end else begin
      if (frame_done) begin
        frames_seen++;
        model_col = idx_flag ? 0 : (model_col + 1) % COLS_C;
        idx_flag  = 1'b0;
        end_cycle = cycle;
        have_end  = 1'b1;
      end
      checkOutput("col_addr", 64'(col_addr), 64'(model_col));
      if (drv_start && !prev_start) begin
        rises++;
        checkOutput("drv_data_at_start", 64'(drv_data), 64'(pattern(model_col)));
        held_data = drv_data;
        if (have_end) checkAtLeast("frame_spacing", cycle - end_cycle, GAP_C);
        start_len = 0;
      end
      if (drv_start) begin
        start_len++;
        checkOutput("drv_data_stable", 64'(drv_data), 64'(held_data));
      end
      if (!drv_start && prev_start) begin
        checkOutput("drv_start_len", 64'(start_len), 64'(exp_start_len));
        last_start_len = start_len;
        end_cycle = cycle;
        have_end  = 1'b1;
      end
      prev_start = drv_start;
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int saved_rises;
    int n;
    reset        = 1'b0;
    enable       = 1'b0;
    frame_tick   = 1'b0;
    index        = 1'b0;
    clear_status = 1'b0;
    idle(3);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("reset_col_addr", 64'(col_addr), 64'd0);
    checkOutput("reset_drv_start", 64'(drv_start), 64'd0);
    checkOutput("reset_drv_data", 64'(drv_data), 64'd0);
    checkOutput("reset_frame_done", 64'(frame_done), 64'd0);
    checkOutput("reset_overrun", 64'(overrun), 64'd0);
    checkOutput("reset_timeout_err", 64'(timeout_err), 64'd0);

    $display("[TB] single frame");
    enable = 1'b1;
    applyStimulus(1, 0, 0);
    waitFrames(1, 100);
    checkOutput("single_col_addr", 64'(col_addr), 64'd1);
    checkOutput("single_drv_data", 64'(drv_data), 64'h00C35A109611);
    checkOutput("single_start_len", 64'(last_start_len), 64'd3);
    idle(25);

    $display("[TB] ticks every 10 clocks");
    applyStimulus(1, 0, 0);
    idle(8);
    applyStimulus(1, 0, 0);
    checkOutput("overrun_second_tick", 64'(overrun), 64'd0);
    idle(8);
    applyStimulus(1, 0, 0);
    checkOutput("overrun_third_tick", 64'(overrun), 64'd1);
    idle(8);
    applyStimulus(1, 0, 0);
    waitFrames(4, 200);
    checkOutput("wrap_col_addr", 64'(col_addr), 64'd0);
    idle(25);

    $display("[TB] clear_status against a concurrent overrun");
    applyStimulus(0, 0, 1);
    checkOutput("overrun_cleared", 64'(overrun), 64'd0);
    applyStimulus(1, 0, 0);
    idle(2);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 1);
    checkOutput("overrun_set_wins", 64'(overrun), 64'd1);
    applyStimulus(0, 0, 1);
    checkOutput("overrun_clear_alone", 64'(overrun), 64'd0);
    waitFrames(6, 200);
    checkOutput("after_pair_col_addr", 64'(col_addr), 64'd2);
    idle(25);

    $display("[TB] index during a frame");
    applyStimulus(1, 0, 0);
    idle(4);
    applyStimulus(0, 1, 0);
    waitFrames(7, 100);
    checkOutput("index_col_addr", 64'(col_addr), 64'd0);
    idle(25);

    $display("[TB] driver never goes busy");
    drv_mode = 1;
    exp_start_len = 16;
    applyStimulus(1, 0, 0);
    n = 0;
    while (!timeout_err && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput("timeout_err_set", 64'(timeout_err), 64'd1);
    checkOutput("timeout_col_addr", 64'(col_addr), 64'd0);
    checkOutput("timeout_no_frame", 64'(frames_seen), 64'd7);
    idle(2);
    checkOutput("timeout_start_len", 64'(last_start_len), 64'd16);
    idle(25);
    applyStimulus(0, 0, 1);
    checkOutput("timeout_err_cleared", 64'(timeout_err), 64'd0);
    drv_mode = 0;
    exp_start_len = 3;

    $display("[TB] enable low ignores ticks");
    saved_rises = rises;
    enable = 1'b0;
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    idle(5);
    enable = 1'b1;
    idle(25);
    checkOutput("disabled_no_start", 64'(rises), 64'(saved_rises));
    checkOutput("disabled_no_overrun", 64'(overrun), 64'd0);

    $display("[TB] reset while busy");
    applyStimulus(1, 0, 0);
    waitFrames(8, 100);
    checkOutput("pre_reset_col_addr", 64'(col_addr), 64'd1);
    idle(25);
    applyStimulus(1, 0, 0);
    idle(5);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_reset_drv_start", 64'(drv_start), 64'd0);
    checkOutput("async_reset_col_addr", 64'(col_addr), 64'd0);
    checkOutput("async_reset_drv_data", 64'(drv_data), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    saved_rises = rises;
    idle(30);
    checkOutput("post_reset_no_start", 64'(rises), 64'(saved_rises));
    checkOutput("post_reset_no_frame", 64'(frames_seen), 64'd8);
    applyStimulus(1, 0, 0);
    waitFrames(9, 100);
    checkOutput("post_reset_col_addr", 64'(col_addr), 64'd1);
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
